// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller: round-robin arbitration of per-core bus requests,
// peer snoop broadcast/collection, and L2 fallback for misses and write-backs.
module snoop_bus_ctrl #(
   parameter int CPU_CORES      = 4,
   parameter int LINE_ADDR_BITS = 6,
   parameter int CACHELINE_BITS = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [CPU_CORES-1:0]                 core_req_valid,
   input  logic [CPU_CORES*LINE_ADDR_BITS-1:0]  core_req_addr,
   input  logic [CPU_CORES*2-1:0]               core_req_type,
   input  logic [CPU_CORES*CACHELINE_BITS-1:0]  core_req_wdata,
   output logic [CPU_CORES-1:0]                 core_req_ready,
   output logic [CPU_CORES-1:0]                 core_resp_valid,
   output logic [CACHELINE_BITS-1:0]            core_resp_data,
   output logic                                 core_resp_shared,
   output logic [CPU_CORES-1:0]                 snoop_valid,
   output logic [LINE_ADDR_BITS-1:0]            snoop_addr,
   output logic [1:0]                           snoop_req,
   input  logic [CPU_CORES-1:0]                 snoop_shared,
   input  logic [CPU_CORES*CACHELINE_BITS-1:0]  snoop_data,
   output logic                                 l2_req_valid,
   output logic [LINE_ADDR_BITS-1:0]            l2_req_addr,
   output logic                                 l2_req_write,
   output logic [CACHELINE_BITS-1:0]            l2_req_wdata,
   input  logic                                 l2_req_ready,
   input  logic                                 l2_resp_valid,
   input  logic [CACHELINE_BITS-1:0]            l2_resp_data
);
   localparam int          GW     = (CPU_CORES > 1) ? $clog2(CPU_CORES) : 1;
   localparam int unsigned NCORES = CPU_CORES;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] BCAST   = 3'd1;
   localparam logic [2:0] COLLECT = 3'd2;
   localparam logic [2:0] L2_REQ  = 3'd3;
   localparam logic [2:0] L2_WAIT = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;

   localparam logic [1:0] BUS_RD   = 2'd0;
   localparam logic [1:0] BUS_UPGR = 2'd2;
   localparam logic [1:0] BUS_WB   = 2'd3;

   logic [2:0]                state;
   logic [GW-1:0]             last_grant, gnt, next_gnt, cand, rsp_idx;
   logic                      gnt_found, rsp_found;
   logic [CPU_CORES-1:0]      gnt_mask, rsp_hits;
   logic [LINE_ADDR_BITS-1:0] req_addr;
   logic [1:0]                req_type;
   logic [CACHELINE_BITS-1:0] req_wdata, resp_data;
   logic                      resp_shared;

   // Search starts one past the last winner so every waiting core is served
   // within CPU_CORES-1 foreign transactions.
   always_comb begin
      next_gnt  = last_grant;
      gnt_found = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NCORES; i++) begin
         cand = GW'((32'(last_grant) + i) % NCORES);
         if (!gnt_found && core_req_valid[cand]) begin
            gnt_found = 1'b1;
            next_gnt  = cand;
         end
      end
   end

   always_comb begin
      gnt_mask      = '0;
      gnt_mask[gnt] = 1'b1;
      rsp_hits      = snoop_shared & ~gnt_mask;
      rsp_found     = 1'b0;
      rsp_idx       = '0;
      for (int unsigned i = 0; i < NCORES; i++) begin
         if (!rsp_found && rsp_hits[GW'(i)]) begin
            rsp_found = 1'b1;
            rsp_idx   = GW'(i);
         end
      end
   end

   always_comb begin
      core_req_ready = '0;
      if (state == IDLE && gnt_found && !reset) core_req_ready[next_gnt] = 1'b1;
      snoop_valid     = (state == BCAST) ? ~gnt_mask : '0;
      core_resp_valid = (state == RESP)  ? gnt_mask  : '0;
   end

   assign core_resp_data   = resp_data;
   assign core_resp_shared = resp_shared;
   assign snoop_addr       = req_addr;
   assign snoop_req        = req_type;
   assign l2_req_valid     = (state == L2_REQ);
   assign l2_req_addr      = req_addr;
   assign l2_req_write     = l2_req_valid && (req_type == BUS_WB);
   assign l2_req_wdata     = req_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= GW'(CPU_CORES - 1);
         gnt         <= '0;
         req_addr    <= '0;
         req_type    <= '0;
         req_wdata   <= '0;
         resp_data   <= '0;
         resp_shared <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt_found) begin
               gnt         <= next_gnt;
               last_grant  <= next_gnt;
               req_addr    <= core_req_addr[next_gnt*LINE_ADDR_BITS +: LINE_ADDR_BITS];
               req_type    <= core_req_type[next_gnt*2 +: 2];
               req_wdata   <= core_req_wdata[next_gnt*CACHELINE_BITS +: CACHELINE_BITS];
               resp_data   <= '0;
               resp_shared <= 1'b0;
               state       <= (core_req_type[next_gnt*2 +: 2] == BUS_WB) ? L2_REQ : BCAST;
            end
            BCAST: state <= COLLECT;
            COLLECT: begin
               if (req_type == BUS_UPGR) begin
                  state <= RESP;
               end else if (rsp_found) begin
                  resp_data   <= snoop_data[rsp_idx*CACHELINE_BITS +: CACHELINE_BITS];
                  resp_shared <= (req_type == BUS_RD);
                  state       <= RESP;
               end else begin
                  state <= L2_REQ;
               end
            end
            L2_REQ: if (l2_req_ready) state <= L2_WAIT;
            L2_WAIT: if (l2_resp_valid) begin
               if (req_type != BUS_WB) resp_data <= l2_resp_data;
               state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/snoop_bus_ctrl.md
SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  CPU_CORES, 4, number of L1 requesters/snoopers.
  LINE_ADDR_BITS, 6, line address width (ADDR_BITS - OFFSET_BITS).
  CACHELINE_BITS, 1, line data width.
REQ-002 SHALL have ports, one per line: name direction width meaning.
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  core_req_valid  in  CPU_CORES  per-core bus request; held until granted.
  core_req_addr  in  CPU_CORES*LINE_ADDR_BITS  per-core line address, core i at slice i.
  core_req_type  in  CPU_CORES*2  per-core bus_req_t (BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3).
  core_req_wdata  in  CPU_CORES*CACHELINE_BITS  write-back data (BUS_WB only).
  core_req_ready  out  CPU_CORES  one-hot grant pulse; request accepted.
  core_resp_valid  out  CPU_CORES  one-hot completion pulse to the granted core.
  core_resp_data  out  CACHELINE_BITS  fill data, valid with core_resp_valid.
  core_resp_shared  out  1  1 = install line S (BUS_RD supplied by peer).
  snoop_valid  out  CPU_CORES  per-core snoop strobe; requester bit always 0.
  snoop_addr  out  LINE_ADDR_BITS  broadcast line address.
  snoop_req  out  2  broadcast bus_req_t.
  snoop_shared  in  CPU_CORES  per-core snooper response (asserted one cycle after strobe).
  snoop_data  in  CPU_CORES*CACHELINE_BITS  per-core supplied data, valid with snoop_shared.
  l2_req_valid  out  1  L2 request, held until l2_req_ready.
  l2_req_addr  out  LINE_ADDR_BITS  L2 line address.
  l2_req_write  out  1  1 = write-back, 0 = read.
  l2_req_wdata  out  CACHELINE_BITS  write-back data.
  l2_req_ready  in  1  L2 accepts request this cycle.
  l2_resp_valid  in  1  L2 read data / write ack.
  l2_resp_data  in  CACHELINE_BITS  L2 read data.

Function
REQ-003 FSM states SHALL be IDLE, BCAST, COLLECT, L2_REQ, L2_WAIT, RESP.
REQ-004 IDLE: if any core_req_valid, SHALL grant by round-robin starting at last_grant+1 (wrapping at CPU_CORES), pulse core_req_ready[g] one cycle, latch addr/type/wdata of g; BUS_WB -> L2_REQ, else -> BCAST.
REQ-005 last_grant SHALL update to g on each grant; no grant outside IDLE.
REQ-006 BCAST (one cycle): snoop_valid = all-ones with bit g cleared, snoop_addr/snoop_req = latched values; -> COLLECT. snoop_valid SHALL be 0 in every other state.
REQ-007 COLLECT: sample snoop_shared masked by ~bit g; responder = lowest-index asserted bit.
REQ-008 COLLECT, BUS_UPGR: -> RESP with data 0, shared 0 regardless of responses.
REQ-009 COLLECT, BUS_RD/BUS_RDX with responder: capture its snoop_data; resp_shared = 1 for BUS_RD, 0 for BUS_RDX; -> RESP.
REQ-010 COLLECT, BUS_RD/BUS_RDX with no responder: -> L2_REQ (read), resp_shared = 0.
REQ-011 L2_REQ: l2_req_valid = 1 with latched addr, l2_req_write = (type == BUS_WB), wdata; on l2_req_ready -> L2_WAIT same edge.
REQ-012 L2_WAIT: on l2_resp_valid capture l2_resp_data (reads only), -> RESP; l2_resp_valid outside L2_WAIT SHALL be ignored.
REQ-013 RESP: pulse core_resp_valid[g] one cycle with captured data/shared; BUS_WB returns data 0; -> IDLE.
REQ-014 Latency from grant edge: peer hit / UPGR resp_valid at +3; L2 path at +3 + L2 handshake cycles; next grant earliest one cycle after RESP.
REQ-015 Requests arriving while busy SHALL wait; no request dropped; starvation bounded to CPU_CORES-1 transactions.

Reset
REQ-016 reset SHALL asynchronously force IDLE, last_grant = CPU_CORES-1, all outputs and captured data/shared 0.
REQ-017 reset mid-transaction SHALL abort it with no core_resp_valid pulse; l2_req_valid drops immediately.

Verification
REQ-018 Core1 BUS_RD addr 0x2A, core3 snoop_shared=1 data=1 at COLLECT -> snoop_valid=4'b1101, resp_valid[1] at +3, data 1, shared 1.
REQ-019 Core0 BUS_RDX, no responders, l2_req_ready after 2 cycles, l2_resp data 1 -> l2_req_write 0, resp data 1, shared 0.
REQ-020 Core2 BUS_UPGR with core0/core1 responding -> resp_valid[2] at +3, data 0, shared 0, no L2 request.
REQ-021 All four cores request continuously after reset -> grant order 0,1,2,3,0; core3 BUS_WB data 1 -> l2_req_write 1, wdata 1, no snoop strobe.
REQ-022 Assert reset during L2_WAIT -> all outputs 0 immediately, no resp pulse, next grant to core 0.
